// File: rtl/mem_turn_scheduler.sv
// Time-slot scheduler sharing the video/CPU SRAM port between the ASIC display
// fetcher and the Z80: drives whichturn, the Z80 WAIT line and an ASIC fetch-done strobe.
module mem_turn_scheduler #(
    parameter int         SLOT_CYCLES  = 4,
    parameter logic [7:0] PAT_M0       = 8'b01010101,
    parameter logic [7:0] PAT_M1       = 8'b01010101,
    parameter logic [7:0] PAT_M2       = 8'b00010001,
    parameter logic [7:0] PAT_M3       = 8'b00010001,
    parameter int         MAX_ASIC_RUN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       display_active,
    input  logic [1:0] screen_mode,
    input  logic       asic_fetch_req,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       rfsh_n,
    output logic       whichturn,
    output logic       cpu_wait_n,
    output logic       asic_fetch_ack,
    output logic [2:0] slot_idx
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int RW = (MAX_ASIC_RUN > 0) ? $clog2(MAX_ASIC_RUN + 1) : 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] ACK_CNT   = CW'(SLOT_CYCLES - 2);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_ASIC_RUN);

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_ASIC = 1'b1;

    logic [CW-1:0] count;
    logic [RW-1:0] asic_run;
    logic          hold_used;

    logic          boundary;
    logic          cpu_pend;
    logic          cpu_wr_active;
    logic          hold_fire;
    logic [7:0]    pattern;
    logic [2:0]    next_slot;
    logic          grant;
    logic          next_turn;

    // Reads are recognised from mreq_n alone; RD carries no extra information here.
    logic unused_inputs;
    assign unused_inputs = rd_n;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        boundary      = (count == SLOT_LAST);
        cpu_pend      = !mreq_n && rfsh_n;
        cpu_wr_active = !mreq_n && !wr_n && rfsh_n;
        next_slot     = slot_idx + 3'd1;
        hold_fire     = (whichturn == OWN_CPU) && cpu_wr_active && !hold_used;
        pattern       = PAT_M0;
        grant         = OWN_CPU;

        case (screen_mode)
            2'd0:    pattern = PAT_M0;
            2'd1:    pattern = PAT_M1;
            2'd2:    pattern = PAT_M2;
            default: pattern = PAT_M3;
        endcase

        // An in-flight write keeps the port one extra slot; a pattern slot lost here is gone.
        if (hold_fire) begin
            grant = OWN_CPU;
        end else if (display_active) begin
            grant = pattern[next_slot];
        end else if (asic_fetch_req && !(cpu_pend && (asic_run == RUN_MAX))) begin
            grant = OWN_ASIC;
        end else begin
            grant = OWN_CPU;
        end

        next_turn = boundary ? grant : whichturn;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count          <= '0;
            slot_idx       <= 3'd0;
            whichturn      <= OWN_ASIC;
            cpu_wait_n     <= 1'b1;
            asic_fetch_ack <= 1'b0;
            asic_run       <= '0;
            hold_used      <= 1'b0;
        end else begin
            count <= boundary ? '0 : count + 1'b1;

            if (boundary) begin
                slot_idx  <= next_slot;
                whichturn <= grant;
                hold_used <= hold_fire;
                if (grant == OWN_ASIC) begin
                    if (asic_run != RUN_MAX) begin
                        asic_run <= asic_run + 1'b1;
                    end
                end else begin
                    asic_run <= '0;
                end
            end

            // WAIT follows the owner of the coming cycle, so it covers a whole ASIC slot.
            cpu_wait_n     <= !(cpu_pend && (next_turn == OWN_ASIC));
            asic_fetch_ack <= (count == ACK_CNT) && (whichturn == OWN_ASIC);
        end
    end

endmodule
